// File: rtl/ll_fifo_traffic_gen.sv
// Closed-loop push/pop initiator for the shared linked-list FIFO; data words are per-queue sequence numbers.
// Optional in-line read-data checker enabled by defining FIFO_GEN_CHECK_EN (adds err/err_sel ports).
module ll_fifo_traffic_gen #(
  parameter int         WIDTH     = 4,
  parameter int         DEPTH     = 2,
  parameter int         NUM_FIFOS = 1,
  parameter int         SEL_WIDTH = (NUM_FIFOS > 1) ? $clog2(NUM_FIFOS) : 1,
  parameter int         CNT_WIDTH = 16,
  parameter int         MIX_LEN   = 16,
  parameter logic [7:0] SEED      = 8'hA5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [$clog2(DEPTH):0] cfg_burst,
  input  logic                   full,
  input  logic [NUM_FIFOS-1:0]   empty,
  input  logic [WIDTH-1:0]       data_out,
  output logic                   push,
  output logic                   pop,
  output logic [SEL_WIDTH-1:0]   push_sel,
  output logic [SEL_WIDTH-1:0]   pop_sel,
  output logic [WIDTH-1:0]       data_in,
  output logic                   busy,
  output logic                   done,
  output logic [CNT_WIDTH-1:0]   push_cnt,
  output logic [CNT_WIDTH-1:0]   pop_cnt
`ifdef FIFO_GEN_CHECK_EN
  ,
  output logic                   err,
  output logic [SEL_WIDTH-1:0]   err_sel
`endif
);

  localparam int MW = (MIX_LEN > 1) ? $clog2(MIX_LEN) : 1;

  // state   | meaning
  // S_IDLE  | waiting for en
  // S_FILL  | round-robin pushes up to cfg_burst or until full
  // S_MIX   | LFSR-driven push/pop for MIX_LEN cycles
  // S_DRAIN | pop lowest non-empty queue until all empty
  // S_DONE  | finished, wait for en low
  typedef enum logic [2:0] {S_IDLE, S_FILL, S_MIX, S_DRAIN, S_DONE} state_t;

  state_t                 r_state, w_state_nxt;
  logic [7:0]             r_lfsr;
  logic [WIDTH-1:0]       r_seq [NUM_FIFOS];
  logic [$clog2(DEPTH):0] r_fill_cnt;
  logic [MW-1:0]          r_mix_cnt;
  logic [SEL_WIDTH-1:0]   r_rr_ptr;
  logic [CNT_WIDTH-1:0]   r_push_cnt, r_pop_cnt;

  logic                   w_push_req, w_pop_req;
  logic [SEL_WIDTH-1:0]   w_push_sel, w_pop_sel;

  always_comb begin
    w_state_nxt = r_state;
    w_push_req  = 1'b0;
    w_pop_req   = 1'b0;
    w_push_sel  = '0;
    w_pop_sel   = '0;
    case (r_state)
      S_IDLE: begin
        if (en) w_state_nxt = S_FILL;
      end
      S_FILL: begin
        w_push_req = (r_fill_cnt < cfg_burst);
        w_push_sel = r_rr_ptr;
        if (!en)                                  w_state_nxt = S_DRAIN;
        else if (full || r_fill_cnt >= cfg_burst) w_state_nxt = S_MIX;
      end
      S_MIX: begin
        w_push_req = r_lfsr[0];
        w_pop_req  = r_lfsr[1];
        w_push_sel = SEL_WIDTH'(int'(r_lfsr[7:4]) % NUM_FIFOS);
        w_pop_sel  = SEL_WIDTH'(int'(r_lfsr[3:2]) % NUM_FIFOS);
        if (!en || r_mix_cnt == MW'(MIX_LEN - 1)) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        w_pop_req = 1'b1;
        for (int i = NUM_FIFOS - 1; i >= 0; i--) begin
          if (!empty[i]) w_pop_sel = SEL_WIDTH'(i);
        end
        if (&empty) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        if (!en) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Legality gating is combinational so the FIFO flags act in the same cycle.
  assign push     = w_push_req & ~full;
  assign pop      = w_pop_req & ~empty[w_pop_sel];
  assign push_sel = w_push_sel;
  assign pop_sel  = w_pop_sel;
  assign data_in  = r_seq[w_push_sel];
  assign busy     = (r_state == S_FILL) || (r_state == S_MIX) || (r_state == S_DRAIN);
  assign done     = (r_state == S_DONE);
  assign push_cnt = r_push_cnt;
  assign pop_cnt  = r_pop_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_lfsr     <= SEED;
      r_fill_cnt <= '0;
      r_mix_cnt  <= '0;
      r_rr_ptr   <= '0;
      r_push_cnt <= '0;
      r_pop_cnt  <= '0;
      for (int i = 0; i < NUM_FIFOS; i++) r_seq[i] <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (push) begin
        r_seq[w_push_sel] <= r_seq[w_push_sel] + 1'b1;
        r_push_cnt        <= r_push_cnt + 1'b1;
      end
      if (pop) r_pop_cnt <= r_pop_cnt + 1'b1;

      if (r_state == S_FILL && push) begin
        r_fill_cnt <= r_fill_cnt + 1'b1;
        r_rr_ptr   <= (r_rr_ptr == SEL_WIDTH'(NUM_FIFOS - 1)) ? '0 : r_rr_ptr + 1'b1;
      end

      // Galois form of x^8+x^6+x^5+x^4+1
      if (r_state == S_MIX) begin
        r_lfsr    <= {1'b0, r_lfsr[7:1]} ^ (r_lfsr[0] ? 8'hB8 : 8'h00);
        r_mix_cnt <= r_mix_cnt + 1'b1;
      end

      if (r_state == S_DONE && !en) begin
        r_fill_cnt <= '0;
        r_mix_cnt  <= '0;
        for (int i = 0; i < NUM_FIFOS; i++) r_seq[i] <= '0;
      end
    end
  end

`ifdef FIFO_GEN_CHECK_EN
  logic [WIDTH-1:0]     r_exp [NUM_FIFOS];
  logic                 r_err;
  logic [SEL_WIDTH-1:0] r_err_sel;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err     <= 1'b0;
      r_err_sel <= '0;
      for (int i = 0; i < NUM_FIFOS; i++) r_exp[i] <= '0;
    end else if (pop) begin
      r_exp[w_pop_sel] <= r_exp[w_pop_sel] + 1'b1;
      if (data_out != r_exp[w_pop_sel]) begin
        r_err <= 1'b1;
        if (!r_err) r_err_sel <= w_pop_sel;
      end
    end
  end

  assign err     = r_err;
  assign err_sel = r_err_sel;

`ifdef FORMAL
  a_pop_order: assert property (@(posedge clk) disable iff (!rst)
    (!pop | (data_out == r_exp[pop_sel])));
`endif
`else
  logic w_unused_data_out;
  assign w_unused_data_out = ^data_out;
`endif

endmodule

// File: tb/tb_ll_fifo_traffic_gen.sv
// Directed bench for ll_fifo_traffic_gen closed around a small behavioural FIFO model.
// Covers the err/err_sel path when FIFO_GEN_CHECK_EN is defined.
module tb_ll_fifo_traffic_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en  = 1'b0;
  logic [2:0] cfg_burst = '0;
  logic       full;
  logic [1:0] empty;
  logic [3:0] data_out;
  logic       push, pop;
  logic [0:0] push_sel, pop_sel;
  logic [3:0] data_in;
  logic       busy, done;
  logic [15:0] push_cnt, pop_cnt;
`ifdef FIFO_GEN_CHECK_EN
  logic       err;
  logic [0:0] err_sel;
`endif

  int n_vec  = 0;
  int n_miss = 0;

  ll_fifo_traffic_gen #(
    .WIDTH(4), .DEPTH(4), .NUM_FIFOS(2), .CNT_WIDTH(16), .MIX_LEN(16), .SEED(8'hA5)
  ) u_dut (
    .clk(clk), .rst(rst), .en(en), .cfg_burst(cfg_burst),
    .full(full), .empty(empty), .data_out(data_out),
    .push(push), .pop(pop), .push_sel(push_sel), .pop_sel(pop_sel), .data_in(data_in),
    .busy(busy), .done(done), .push_cnt(push_cnt), .pop_cnt(pop_cnt)
`ifdef FIFO_GEN_CHECK_EN
    , .err(err), .err_sel(err_sel)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  // behavioural two-queue FIFO sharing cap entries
  logic [3:0] m_mem  [2][4];
  logic [1:0] m_head [2];
  logic [1:0] m_tail [2];
  logic [2:0] m_cnt  [2];
  logic [3:0] m_exp  [2];
  int         cap        = 4;
  bit         force_mode = 1'b0;
  bit         corrupt    = 1'b0;
  int         q0_pops;
  int         mon_push, mon_pop;

  always_comb begin
    full     = force_mode || ((int'(m_cnt[0]) + int'(m_cnt[1])) >= cap);
    empty[0] = force_mode || (m_cnt[0] == 3'd0);
    empty[1] = force_mode || (m_cnt[1] == 3'd0);
    data_out = m_mem[pop_sel][m_head[pop_sel]];
    if (corrupt && pop_sel == 1'b0 && q0_pops == 2) data_out = 4'hF;
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int q = 0; q < 2; q++) begin
        m_head[q] <= '0; m_tail[q] <= '0; m_cnt[q] <= '0; m_exp[q] <= '0;
      end
      q0_pops <= 0;
    end else begin
      for (int q = 0; q < 2; q++)
        m_cnt[q] <= 3'(int'(m_cnt[q]) + ((push && push_sel == 1'(q)) ? 1 : 0)
                                       - ((pop && pop_sel == 1'(q)) ? 1 : 0));
      if (push) begin
        m_mem[push_sel][m_tail[push_sel]] <= data_in;
        m_tail[push_sel] <= m_tail[push_sel] + 2'd1;
      end
      if (pop) begin
        m_head[pop_sel] <= m_head[pop_sel] + 2'd1;
        m_exp[pop_sel]  <= m_exp[pop_sel] + 4'd1;
        if (pop_sel == 1'b0) q0_pops <= q0_pops + 1;
      end
    end
  end

  // legality and per-queue ordering, sampled mid-cycle
  always @(negedge clk or negedge rst) begin
    if (!rst) begin
      mon_push <= 0;
      mon_pop  <= 0;
    end else begin
      if (push) begin
        mon_push <= mon_push + 1;
        chk("push_while_full", 32'(full), 32'd0);
      end
      if (pop) begin
        mon_pop <= mon_pop + 1;
        chk("pop_while_empty", 32'(empty[pop_sel]), 32'd0);
        if (!corrupt) chk("pop_order", 32'(data_out), 32'(m_exp[pop_sel]));
      end
    end
  end

  task automatic do_reset();
    rst = 1'b0; en = 1'b0; cfg_burst = '0; force_mode = 1'b0; corrupt = 1'b0; cap = 4;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_done(input int budget, input string tag);
    for (int c = 0; c < budget && !done; c++) @(negedge clk);
    chk(tag, 32'(done), 32'd1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_push"},     32'(push),     32'd0);
    chk({tag, "_pop"},      32'(pop),      32'd0);
    chk({tag, "_busy"},     32'(busy),     32'd0);
    chk({tag, "_done"},     32'(done),     32'd0);
    chk({tag, "_psel"},     32'(push_sel), 32'd0);
    chk({tag, "_osel"},     32'(pop_sel),  32'd0);
    chk({tag, "_din"},      32'(data_in),  32'd0);
    chk({tag, "_push_cnt"}, 32'(push_cnt), 32'd0);
    chk({tag, "_pop_cnt"},  32'(pop_cnt),  32'd0);
  endtask

  // expected strobes for the first nine cycles after en with cfg_burst=2, SEED=A5
  //               n1 n2 n3 n4 n5 n6 n7 n8 n9
  logic [8:0] d_push  = 9'b0_1010_1011;  // bit i = cycle n(i+1)
  logic [8:0] d_pop   = 9'b0_0101_0000;
  logic [8:0] d_psel  = 9'b0_0010_0010;
  logic [3:0] d_din [9] = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd0, 4'd1, 4'd0, 4'd2, 4'd0};
  logic [3:0] a_din [4] = '{4'd0, 4'd0, 4'd1, 4'd1};

  initial begin
    int k;
    bit found;

    #2;
    chk_all_zero("reset");
    rst = 1'b1;
    @(negedge clk);

    // FILL round robin then closed-loop run to completion
    do_reset();
    cfg_burst = 3'd4; en = 1'b1;
    k = 0;
    for (int c = 0; c < 20 && k < 4; c++) begin
      @(negedge clk);
      if (push) begin
        chk("A_fill_sel", 32'(push_sel), 32'(k % 2));
        chk("A_fill_din", 32'(data_in),  32'(a_din[k]));
        k++;
      end
    end
    chk("A_fill_pushes", 32'(k), 32'd4);
    wait_done(300, "A_done");
    chk("A_busy_in_done", 32'(busy), 32'd0);
    chk("A_push_cnt", 32'(push_cnt), 32'(mon_push));
    chk("A_pop_cnt",  32'(pop_cnt),  32'(mon_push));
    en = 1'b0;
    repeat (2) @(negedge clk);
    chk("A_back_idle", 32'(done), 32'd0);

    // FILL stops on full before cfg_burst is reached
    do_reset();
    cap = 2; cfg_burst = 3'd3; en = 1'b1;
    k = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (push) begin
        chk("B_fill_din", 32'(data_in), 32'd0);
        k++;
      end
    end
    chk("B_fill_pushes", 32'(k), 32'd2);
    en = 1'b0;
    wait_done(100, "B_done");
    chk("B_pop_cnt", 32'(pop_cnt), 32'd2);

    // full and all-empty pinned: nothing may be issued in any state
    do_reset();
    force_mode = 1'b1; cfg_burst = 3'd4; en = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      chk("C_push", 32'(push), 32'd0);
      chk("C_pop",  32'(pop),  32'd0);
    end
    chk("C_done",     32'(done),     32'd1);
    chk("C_push_cnt", 32'(push_cnt), 32'd0);
    chk("C_pop_cnt",  32'(pop_cnt),  32'd0);

    // hand-traced LFSR sequence, en dropped in MIX cycle 5
    do_reset();
    cap = 4; cfg_burst = 3'd2; en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      chk("D_push", 32'(push), 32'(d_push[i]));
      chk("D_pop",  32'(pop),  32'(d_pop[i]));
      if (d_push[i]) begin
        chk("D_push_sel", 32'(push_sel), 32'(d_psel[i]));
        chk("D_din",      32'(data_in),  32'(d_din[i]));
      end
      if (d_pop[i]) chk("D_pop_sel", 32'(pop_sel), 32'd0);
    end
    en = 1'b0;
    for (int c = 0; c < 30 && !done; c++) begin
      @(negedge clk);
      chk("D_no_push_drain", 32'(push), 32'd0);
    end
    chk("D_done",     32'(done),     32'd1);
    chk("D_push_cnt", 32'(push_cnt), 32'd5);
    chk("D_pop_cnt",  32'(pop_cnt),  32'd5);

    // async reset in FILL while data_in=1
    do_reset();
    cfg_burst = 3'd4; en = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk);
      if (push && data_in == 4'd1) found = 1'b1;
    end
    chk("E_saw_din1", 32'(found), 32'd1);
    rst = 1'b0;
    #1;
    chk_all_zero("E_async");
    @(negedge clk);
    rst = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk);
      if (push) begin
        found = 1'b1;
        chk("E_first_din", 32'(data_in),  32'd0);
        chk("E_first_sel", 32'(push_sel), 32'd0);
      end
    end
    chk("E_push_after_rst", 32'(found), 32'd1);
    en = 1'b0;
    wait_done(100, "E_done");

`ifdef FIFO_GEN_CHECK_EN
    // third pop of queue 0 (first DRAIN pop in the traced sequence) returns 4'hF
    do_reset();
    corrupt = 1'b1; cap = 4; cfg_burst = 3'd2; en = 1'b1;
    repeat (9) @(negedge clk);
    chk("F_err_before", 32'(err), 32'd0);
    en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("F_err_set", 32'(err),     32'd1);
    chk("F_err_sel", 32'(err_sel), 32'd0);
    wait_done(100, "F_done");
    chk("F_err_sticky", 32'(err), 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ll_fifo_traffic_gen.md
Name: ll_fifo_traffic_gen

Overview:
- Closed-loop stimulus driver for the shared linked-list FIFO. It is the initiator side of the push/pop interface.
- Generates push/pop/push_sel/pop_sel/data_in that always honour the FIFO's legality rules: no push when full, no pop of an empty queue.
- Data words are per-queue sequence numbers, so ordering violations are detectable downstream.
- Used in simulation benches and as a bounded environment for formal runs in place of free inputs.

Parameters:
- WIDTH, 4, data word width.
- DEPTH, 2, total shared FIFO entries.
- NUM_FIFOS, 1, number of logical queues.
- SEL_WIDTH, max(1,$clog2(NUM_FIFOS)), select width.
- CNT_WIDTH, 16, width of statistics counters.
- MIX_LEN, 16, cycles spent in random MIX phase.
- SEED, 8'hA5, LFSR reset value; must be nonzero.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  run request.
- cfg_burst  in  $clog2(DEPTH)+1  max pushes in FILL.
- full  in  1  from FIFO.
- empty  in  NUM_FIFOS  per-queue empty from FIFO.
- data_out  in  WIDTH  FIFO read data, valid in the pop cycle.
- push  out  1  push strobe.
- pop  out  1  pop strobe.
- push_sel  out  SEL_WIDTH  target queue of push.
- pop_sel  out  SEL_WIDTH  source queue of pop.
- data_in  out  WIDTH  push data.
- busy  out  1  FSM not IDLE/DONE.
- done  out  1  DONE state.
- push_cnt  out  CNT_WIDTH  total pushes issued.
- pop_cnt  out  CNT_WIDTH  total pops issued.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; lfsr=SEED.
  - seq[c]=0, fill_cnt=0, mix_cnt=0, rr_ptr=0, push_cnt=0, pop_cnt=0.
  - Outputs: push=0, pop=0, busy=0, done=0, sels=0, data_in=0.
- Output timing:
  - push/pop are combinational from registered state and the current full/empty. Zero-cycle reaction.
  - push is forced 0 whenever full=1.
  - pop is forced 0 whenever empty[pop_sel]=1.
- Data rule:
  - data_in = seq[push_sel].
  - seq[push_sel] increments (mod 2^WIDTH) on each accepted push.
- FSM:
  - IDLE: en=1 -> FILL.
  - FILL:
    - push=1 with push_sel=rr_ptr while !full and fill_cnt<cfg_burst; pop=0.
    - rr_ptr advances mod NUM_FIFOS per push.
    - Goes to MIX when full=1 or fill_cnt==cfg_burst. cfg_burst=0 goes to MIX immediately.
  - MIX:
    - 8-bit Galois LFSR, polynomial x^8+x^6+x^5+x^4+1, steps every MIX cycle.
    - push request = lfsr[0]; pop request = lfsr[1].
    - push_sel = lfsr[7:4] mod NUM_FIFOS, forced to 0 if out of range.
    - pop_sel = lfsr[3:2]-derived, same reduction.
    - Simultaneous push and pop are allowed, including to the same queue. A pop of a queue that is empty this cycle is suppressed even if the push targets it.
    - mix_cnt counts to MIX_LEN-1, then -> DRAIN.
  - DRAIN: push=0. pop_sel = lowest-index queue with empty=0, pop=1. All empty -> DONE.
  - DONE: done=1, all strobes 0. en=0 -> IDLE; fill_cnt, mix_cnt and seq are cleared on IDLE entry.
- en=0 in FILL or MIX -> DRAIN next cycle. In-flight data is always drained, never abandoned.
- push_cnt and pop_cnt increment on the respective strobes and wrap at 2^CNT_WIDTH.
- Asynchronous reset mid-operation: all state returns to reset values immediately. The attached FIFO must be reset by the same rst.

Optional Feature:
- FIFO_GEN_CHECK_EN defined:
  - Adds exp[c] (WIDTH bits, reset 0) per queue. Each pop compares data_out against exp[pop_sel], then increments exp[pop_sel].
  - A mismatch sets sticky output err (1 bit, reset 0, cleared only by reset).
  - Adds output err_sel (SEL_WIDTH) capturing the first failing queue.
  - Also drives the formal assertion `assert(!pop | (data_out == exp[pop_sel]))`.
- Undefined: err and err_sel ports absent, no checking logic.

Test Plan:
- DEPTH=2, NUM_FIFOS=1, cfg_burst=3, en held 1 -> FILL pushes data 0,1 and stops on full=1. MIX runs 16 cycles; DRAIN empties; done=1. Final push_cnt==pop_cnt.
- DEPTH=4, NUM_FIFOS=2, cfg_burst=4 -> FILL pushes with push_sel 0,1,0,1 and data 0,0,1,1. Popped data per queue is strictly 0,1,... in order.
- Force full=1 and empty=all-ones throughout -> push and pop stay 0 every cycle in every state. Counters stay 0.
- Deassert en during MIX cycle 5 -> next state DRAIN, no further pushes. done rises once all empty=1.
- Pull rst low mid-FILL with data_in=1 -> all outputs 0 at once. After release and en=1, the first push carries data_in=0.
- FIFO_GEN_CHECK_EN defined, bench corrupts data_out to 4'hF on the third pop of queue 0 -> err=1 and err_sel=0 the next cycle, and err stays 1.
